// File: rtl/ofifo_psum.sv
// Output FIFO bank: one psum lane per array column, popped together as an aligned row.
// Optional ReLU on the output path when OFIFO_RELU_EN is defined.
module ofifo_psum #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col*psum_bw-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_ready,
    output logic                     o_overflow
);

    localparam int aw = $clog2(depth);

    logic [psum_bw-1:0] mem_r  [col][depth];
    logic [aw:0]        wptr_r [col];
    logic [aw:0]        rptr_r [col];
    logic               overflow_r;

    logic [col-1:0]     empty_s;
    logic [col-1:0]     full_s;
    logic [col-1:0]     wr_ok_s;
    logic [col-1:0]     drop_s;
    logic               pop_s;
    logic [psum_bw-1:0] head_s [col];

    // Per-lane empty/full from the wrap-bit pointer pair, plus write acceptance
    always_comb begin
        empty_s = {col{1'b0}};
        full_s  = {col{1'b0}};
        for (int i = 0; i < col; i++) begin
            empty_s[i] = (wptr_r[i] == rptr_r[i]);
            full_s[i]  = (wptr_r[i][aw-1:0] == rptr_r[i][aw-1:0]) &&
                         (wptr_r[i][aw] != rptr_r[i][aw]);
        end
    end

    assign o_valid    = ~|empty_s;
    assign o_full     = |full_s;
    assign o_ready    = ~o_full;
    assign o_overflow = overflow_r;
    assign pop_s      = rd & o_valid;
    // A full lane still accepts a write when the row is popped on the same edge
    assign wr_ok_s    = wr & (~full_s | {col{pop_s}});
    assign drop_s     = wr & ~wr_ok_s;

    // Pointer and sticky overflow update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < col; i++) begin
                wptr_r[i] <= {(aw+1){1'b0}};
                rptr_r[i] <= {(aw+1){1'b0}};
            end
            overflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < col; i++) begin
                if (wr_ok_s[i]) begin
                    wptr_r[i] <= wptr_r[i] + {{aw{1'b0}}, 1'b1};
                end
                if (pop_s) begin
                    rptr_r[i] <= rptr_r[i] + {{aw{1'b0}}, 1'b1};
                end
            end
            if (|drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Lane storage; deliberately not reset, contents are hidden by the pointers
    always_ff @(posedge clk) begin
        for (int i = 0; i < col; i++) begin
            if (wr_ok_s[i] && !reset) begin
                mem_r[i][wptr_r[i][aw-1:0]] <= in[psum_bw*i +: psum_bw];
            end
        end
    end

    // Head-of-lane selection
    always_comb begin
        for (int i = 0; i < col; i++) begin
            head_s[i] = mem_r[i][rptr_r[i][aw-1:0]];
        end
    end

    // First-word-fall-through output, zeroed while any lane is empty
    always_comb begin
        out = {(col*psum_bw){1'b0}};
        for (int i = 0; i < col; i++) begin
            if (!o_valid) begin
                out[psum_bw*i +: psum_bw] = {psum_bw{1'b0}};
            end else begin
`ifdef OFIFO_RELU_EN
                if (head_s[i][psum_bw-1]) begin
                    out[psum_bw*i +: psum_bw] = {psum_bw{1'b0}};
                end else begin
                    out[psum_bw*i +: psum_bw] = head_s[i];
                end
`else
                out[psum_bw*i +: psum_bw] = head_s[i];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ofifo_psum.sv
// Directed self-checking bench for ofifo_psum (default geometry 8 lanes x 16 bits x 8 deep).
module tb_ofifo_psum;

    logic         clk;
    logic         reset;
    logic [127:0] in;
    logic [7:0]   wr;
    logic         rd;
    logic [127:0] out;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
    logic         o_overflow;

    int n_cmp;
    int n_err;
    int exp_q[$];
    int popped;

    ofifo_psum #(.col(8), .psum_bw(16), .depth(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .out        (out),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] row_vec(input int base);
        logic [127:0] v;
        v = 128'd0;
        for (int i = 0; i < 8; i++) v[16*i +: 16] = 16'(base + i);
        return v;
    endfunction

    task automatic write_row(input int base, input logic do_rd);
        in = row_vec(base);
        wr = 8'hFF;
        rd = do_rd;
        step();
        wr = 8'h00;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [127:0] relu_in;
        logic [127:0] relu_exp;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        in    = 128'd0;
        wr    = 8'h00;
        rd    = 1'b0;
        step();
        reset = 1'b0;
        check("rst_valid", {127'd0, o_valid}, 128'd0);
        check("rst_full", {127'd0, o_full}, 128'd0);
        check("rst_ready", {127'd0, o_ready}, 128'd1);
        check("rst_ovf", {127'd0, o_overflow}, 128'd0);
        check("rst_out", out, 128'd0);

        // basic transfer
        write_row(100, 1'b0);
        check("basic_valid", {127'd0, o_valid}, 128'd1);
        check("basic_out", out, row_vec(100));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("basic_pop_valid", {127'd0, o_valid}, 128'd0);
        check("basic_pop_out", out, 128'd0);

        // systolic skew: lane i written at cycle i
        in = row_vec(200);
        for (int i = 0; i < 8; i++) begin
            wr = 8'(1 << i);
            step();
            check("skew_valid", {127'd0, o_valid}, {127'd0, (i == 7)});
        end
        wr = 8'h00;
        check("skew_out", out, row_vec(200));
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("skew_drain", {127'd0, o_valid}, 128'd0);

        // full, then dropped write
        for (int k = 0; k < 8; k++) write_row(k * 16, 1'b0);
        check("full_flag", {127'd0, o_full}, 128'd1);
        check("full_ready", {127'd0, o_ready}, 128'd0);
        check("full_no_ovf", {127'd0, o_overflow}, 128'd0);
        write_row(999, 1'b0);
        check("ovf_set", {127'd0, o_overflow}, 128'd1);
        check("ovf_head", out, row_vec(0));
        step();
        check("ovf_sticky", {127'd0, o_overflow}, 128'd1);

        // full with simultaneous pop: write accepted, no overflow
        do_reset();
        check("reset_clears_ovf", {127'd0, o_overflow}, 128'd0);
        for (int k = 0; k < 8; k++) write_row(k * 16, 1'b0);
        write_row(128, 1'b1);
        check("pushpop_ovf", {127'd0, o_overflow}, 128'd0);
        check("pushpop_full", {127'd0, o_full}, 128'd1);
        for (int k = 1; k <= 8; k++) begin
            check("pushpop_drain", out, row_vec(k * 16));
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        check("pushpop_empty", {127'd0, o_valid}, 128'd0);

        // wrap-around streaming against a queue model
        do_reset();
        popped = 0;
        for (int r = 0; r < 20; r++) begin
            logic do_rd;
            do_rd = (r % 3 != 0);
            if (do_rd && exp_q.size() > 0) begin
                check("wrap_out", out, row_vec(exp_q.pop_front()));
                popped++;
            end
            exp_q.push_back(r * 16);
            write_row(r * 16, do_rd);
        end
        while (exp_q.size() > 0) begin
            check("wrap_drain_valid", {127'd0, o_valid}, 128'd1);
            check("wrap_drain_out", out, row_vec(exp_q.pop_front()));
            popped++;
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        check("wrap_count", 128'(popped), 128'd20);
        check("wrap_empty", {127'd0, o_valid}, 128'd0);
        check("wrap_no_ovf", {127'd0, o_overflow}, 128'd0);

        // reset mid-stream with 5 entries held and overflow already set
        for (int k = 0; k < 8; k++) write_row(300 + k, 1'b0);
        write_row(777, 1'b0);
        for (int k = 0; k < 3; k++) begin
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        check("mid_pre_ovf", {127'd0, o_overflow}, 128'd1);
        check("mid_pre_head", out, row_vec(303));
        reset = 1'b1;
        in    = row_vec(555);
        wr    = 8'hFF;
        rd    = 1'b1;
        step();
        reset = 1'b0;
        wr    = 8'h00;
        rd    = 1'b0;
        check("mid_valid", {127'd0, o_valid}, 128'd0);
        check("mid_full", {127'd0, o_full}, 128'd0);
        check("mid_ovf", {127'd0, o_overflow}, 128'd0);
        check("mid_out", out, 128'd0);
        step();
        check("mid_write_ignored", {127'd0, o_valid}, 128'd0);

        // ReLU / pass-through of negative psums
        relu_in = 128'd0;
        relu_in[15:0]    = 16'hFFFB;
        relu_in[31:16]   = 16'h0007;
        for (int i = 2; i < 7; i++) relu_in[16*i +: 16] = 16'(16'h0010 * i);
        relu_in[127:112] = 16'h8000;
        relu_exp = relu_in;
`ifdef OFIFO_RELU_EN
        relu_exp[15:0]    = 16'h0000;
        relu_exp[127:112] = 16'h0000;
`endif
        in = relu_in;
        wr = 8'hFF;
        step();
        wr = 8'h00;
        check("relu_out", out, relu_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ofifo_psum.md
# ofifo_psum

Output FIFO bank that collects partial sums from the bottom row of the MAC-tile array. It has one independent FIFO lane per array column, and each lane captures the `out_s` psum of that column's last tile whenever the lane's write strobe is high. A row is released to the downstream SFU/memory path only when every lane holds at least one entry, so all columns are popped together as one aligned output vector.

## Interface
Parameters:
- `col`, 8: number of array columns, one FIFO lane each.
- `psum_bw`, 16: width of one psum (two's complement).
- `depth`, 8: entries per lane. Must be a power of two and at least 2.

Ports:
- `clk`  input  1: single clock. All state updates on the rising edge.
- `reset`  input  1: synchronous, active-high. Sampled on the rising edge of `clk`.
- `in`  input  col*psum_bw: psums. Lane i uses `in[psum_bw*(i+1)-1 : psum_bw*i]`.
- `wr`  input  col: per-lane write strobe, driven by the south-edge tile valid.
- `rd`  input  1: pops one entry from every lane.
- `out`  output  col*psum_bw: head entry of each lane, packed like `in`.
- `o_valid`  output  1: every lane is non-empty.
- `o_full`  output  1: at least one lane is full.
- `o_ready`  output  1: equals `~o_full`.
- `o_overflow`  output  1: sticky flag, set when a write is dropped.

## Operation
- Each lane has a `depth`-entry register array, plus a write pointer and a read pointer.
  - Each pointer is `$clog2(depth)+1` bits wide.
  - The MSB of a pointer is the wrap bit.
  - A lane is empty when its pointers are equal.
  - A lane is full when the low bits are equal and the wrap bits differ.
- Write, per lane:
  - If `wr[i]`=1 and lane i is not full, store `in` lane i at the write pointer and increment the write pointer.
  - If `wr[i]`=1 and lane i is full, the write is accepted only if a pop happens on the same edge (`rd`=1 and `o_valid`=1).
  - Otherwise the data is dropped, and `o_overflow` is set to 1 on that edge.
- Read:
  - `rd`=1 with `o_valid`=1 increments every lane's read pointer on the same edge.
  - `rd`=1 with `o_valid`=0 is ignored: no pointer moves, and no error is flagged.
- Simultaneous read and write on one lane: both take effect, and that lane's occupancy is unchanged. An empty lane cannot be written and read in the same cycle, because `o_valid` is 0 while the lane is empty.
- Pointers wrap modulo `2*depth`, so no special case is needed at wrap-around.
- `out` is first-word-fall-through: it is combinational from each lane's head entry.
- `out` is forced to all zeros whenever `o_valid`=0, so uninitialised storage is never exposed.
- Storage arrays are not reset. Only pointers and flags are reset.

## Timing
- Reset: all pointers go to 0.
  - `o_valid`=0, `o_full`=0, `o_ready`=1, `o_overflow`=0, `out`=0 from the first edge with `reset`=1.
  - Reset has priority over `wr` and `rd` in the same cycle.
  - Reset mid-operation discards all contents immediately.
- Write-to-output latency is 1 cycle. Data written at edge N appears on `out`, with `o_valid`=1 (if all other lanes are non-empty), after edge N.
- Flags are registered-pointer functions, combinational from the pointers. They update in the cycle after the causing edge.
- After a pop at edge N, `out` shows the next head entry after edge N.
- `o_overflow` stays 1 until reset.

## Configuration
- `OFIFO_RELU_EN` defined: ReLU is applied at the output. Each lane of `out` is 0 if its head psum is negative (MSB=1), otherwise it is passed unchanged. Storage always keeps the raw psum.
- `OFIFO_RELU_EN` undefined: `out` passes the head psum unchanged, including negative values.
- Flag and pointer behaviour is identical in both builds.

## Test plan
- Reset and basic transfer:
  - Stimulus: reset; write lane i = 100+i on all 8 lanes in one cycle.
  - Required: `o_valid`=1 the next cycle and `out` lane i = 100+i.
  - Then: `rd`=1 for one cycle gives `o_valid`=0 and `out`=0.
- Skewed columns:
  - Stimulus: lane i written at cycle i, the systolic skew.
  - Required: `o_valid` stays 0 until after lane 7's write, then the full row is aligned on `out`.
- Full and overflow:
  - Stimulus: 8 writes to all lanes.
  - Required: `o_full`=1 and `o_ready`=0.
  - Then: a 9th write with `rd`=0 leaves contents unchanged and sets `o_overflow`=1, which persists.
  - Then: a 9th write with `rd`=1 is accepted, with no overflow.
- Wrap-around:
  - Stimulus: stream 20 rows with interleaved `rd`, values `row*16+lane`.
  - Required: the output order exactly matches the input order, with no loss.
- Reset mid-stream:
  - Stimulus: with 5 entries held, assert `reset` together with `wr` and `rd`.
  - Required: after that edge, `o_valid`=0, `o_full`=0, `o_overflow`=0, and the write is ignored.
- ReLU:
  - Stimulus: write -5 (0xFFFB) and 7 (0x0007).
  - Required: with `OFIFO_RELU_EN` defined, `out` lanes are 0 and 7. Without it, `out` lanes are 0xFFFB and 7.
